psram_arbiter: RTL and testbench



---
 rtl/psram_arbiter.sv | 161 ++++++++++++++++
 tb/tb_psram_arbiter.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/psram_arbiter.sv
// Two-client PSRAM command arbiter with round-robin tie-break, a minimum command gap and a grant watchdog.
// Commands pass straight through from the active owner; address, command and write data hold between grants.
module psram_arbiter #(
  parameter int MEMORY_BURST   = 32,
  parameter int CMD_GAP        = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        calib_done,
  input  logic        rd_rq,
  input  logic [20:0] rd_addr,
  input  logic        rd_en,
  output logic        rd_ack,
  input  logic        wr_rq,
  input  logic [20:0] wr_addr,
  input  logic        wr_en,
  input  logic [31:0] wr_data,
  output logic        wr_ack,
  output logic        mem_cmd,
  output logic        mem_cmd_en,
  output logic [20:0] mem_addr,
  output logic [31:0] mem_wr_data,
  output logic        busy,
  output logic        timeout_err
);

  if (CMD_GAP < 1 || CMD_GAP > 63 || TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535 || MEMORY_BURST < 1)
  begin : g_param_range
    $error("psram_arbiter: parameter out of range");
  end

  localparam logic [2:0] S_WAIT_CALIB = 3'd0;
  localparam logic [2:0] S_IDLE       = 3'd1;
  localparam logic [2:0] S_RD_GRANT   = 3'd2;
  localparam logic [2:0] S_RD_ACTIVE  = 3'd3;
  localparam logic [2:0] S_WR_GRANT   = 3'd4;
  localparam logic [2:0] S_WR_ACTIVE  = 3'd5;
  localparam logic [2:0] S_GAP        = 3'd6;

  localparam logic [5:0]  GAP_LOAD  = 6'(CMD_GAP - 1);
  localparam logic [15:0] WDOG_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [2:0]  state_q, state_d;
  logic [5:0]  gap_q, gap_d;
  logic [15:0] wdog_q, wdog_d;
  logic        last_wr_q, last_wr_d;
  logic        err_q, err_d;
  logic        calib_lost_q, calib_lost_d;
  logic        rd_ack_q, rd_ack_d;
  logic        wr_ack_q, wr_ack_d;
  logic        cmd_q;
  logic [20:0] addr_q;
  logic [31:0] wdata_q;
  logic        rd_act, wr_act;

  assign rd_act = (state_q == S_RD_ACTIVE);
  assign wr_act = (state_q == S_WR_ACTIVE);

  always_comb begin
    state_d      = state_q;
    gap_d        = gap_q;
    wdog_d       = wdog_q;
    last_wr_d    = last_wr_q;
    err_d        = err_q;
    calib_lost_d = calib_lost_q | ~calib_done;
    rd_ack_d     = 1'b0;
    wr_ack_d     = 1'b0;
    case (state_q)
      S_WAIT_CALIB: begin
        calib_lost_d = 1'b0;
        if (calib_done) state_d = S_IDLE;
      end
      S_IDLE: begin
        // On a tie the class not served last wins.
        if (!calib_done) begin
          state_d = S_WAIT_CALIB;
        end else if (wr_rq && (!rd_rq || !last_wr_q)) begin
          state_d  = S_WR_GRANT;
          wr_ack_d = 1'b1;
        end else if (rd_rq) begin
          state_d  = S_RD_GRANT;
          rd_ack_d = 1'b1;
        end
      end
      S_RD_GRANT: begin
        last_wr_d = 1'b0;
        wdog_d    = '0;
        state_d   = S_RD_ACTIVE;
      end
      S_WR_GRANT: begin
        last_wr_d = 1'b1;
        wdog_d    = '0;
        state_d   = S_WR_ACTIVE;
      end
      S_RD_ACTIVE, S_WR_ACTIVE: begin
        wdog_d = wdog_q + 16'd1;
        if (!(rd_act ? rd_rq : wr_rq)) begin
          state_d = S_GAP;
          gap_d   = GAP_LOAD;
        end else if (wdog_q == WDOG_LAST) begin
          err_d   = 1'b1;
          state_d = S_GAP;
          gap_d   = GAP_LOAD;
        end
      end
      S_GAP: begin
        if (gap_q == 6'd0) begin
          state_d = (calib_lost_q || !calib_done) ? S_WAIT_CALIB : S_IDLE;
        end else begin
          gap_d = gap_q - 6'd1;
        end
      end
      default: state_d = S_WAIT_CALIB;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_WAIT_CALIB;
      gap_q        <= '0;
      wdog_q       <= '0;
      last_wr_q    <= 1'b0;
      err_q        <= 1'b0;
      calib_lost_q <= 1'b0;
      rd_ack_q     <= 1'b0;
      wr_ack_q     <= 1'b0;
      cmd_q        <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      gap_q        <= gap_d;
      wdog_q       <= wdog_d;
      last_wr_q    <= last_wr_d;
      err_q        <= err_d;
      calib_lost_q <= calib_lost_d;
      rd_ack_q     <= rd_ack_d;
      wr_ack_q     <= wr_ack_d;
      if (rd_act) begin
        cmd_q  <= 1'b0;
        addr_q <= rd_addr;
      end else if (wr_act) begin
        cmd_q   <= 1'b1;
        addr_q  <= wr_addr;
        wdata_q <= wr_data;
      end
    end
  end

  // Only the current owner's strobe can reach the controller.
  assign mem_cmd_en  = (rd_act & rd_en) | (wr_act & wr_en);
  assign mem_cmd     = wr_act ? 1'b1 : (rd_act ? 1'b0 : cmd_q);
  assign mem_addr    = wr_act ? wr_addr : (rd_act ? rd_addr : addr_q);
  assign mem_wr_data = wr_act ? wr_data : wdata_q;
  assign busy        = (state_q != S_IDLE);
  assign timeout_err = err_q;
  assign rd_ack      = rd_ack_q;
  assign wr_ack      = wr_ack_q;

endmodule

// File: tb/tb_psram_arbiter.sv
// Directed bench for psram_arbiter: calibration gating, pass-through, round-robin, gap, watchdog, async reset.
module tb_psram_arbiter;

  logic        clk = 1'b0;
  logic        reset_n, calib_done;
  logic        rd_rq, rd_en, rd_ack;
  logic [20:0] rd_addr;
  logic        wr_rq, wr_en, wr_ack;
  logic [20:0] wr_addr;
  logic [31:0] wr_data;
  logic        mem_cmd, mem_cmd_en, busy, timeout_err;
  logic [20:0] mem_addr;
  logic [31:0] mem_wr_data;

  int checks = 0;
  int errors = 0;
  int cycle  = 0;

  psram_arbiter #(.MEMORY_BURST(32), .CMD_GAP(4), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .reset_n(reset_n), .calib_done(calib_done),
    .rd_rq(rd_rq), .rd_addr(rd_addr), .rd_en(rd_en), .rd_ack(rd_ack),
    .wr_rq(wr_rq), .wr_addr(wr_addr), .wr_en(wr_en), .wr_data(wr_data), .wr_ack(wr_ack),
    .mem_cmd(mem_cmd), .mem_cmd_en(mem_cmd_en), .mem_addr(mem_addr), .mem_wr_data(mem_wr_data),
    .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    cycle++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_rd_ack"}, rd_ack, 0);
    chk({tag, "_wr_ack"}, wr_ack, 0);
    chk({tag, "_mem_cmd"}, mem_cmd, 0);
    chk({tag, "_mem_cmd_en"}, mem_cmd_en, 0);
    chk({tag, "_mem_addr"}, mem_addr, 0);
    chk({tag, "_mem_wr_data"}, mem_wr_data, 0);
    chk({tag, "_busy"}, busy, 1);
    chk({tag, "_timeout_err"}, timeout_err, 0);
  endtask

  // Wait (bounded) for either ack; returns with the ack visible.
  task automatic wait_ack();
    int n;
    n = 0;
    while (!(rd_ack || wr_ack) && n < 60) begin
      tick();
      n++;
    end
  endtask

  initial begin
    int k;
    int prev;
    logic seen;

    reset_n = 1'b0; calib_done = 1'b0;
    rd_rq = 1'b0; rd_addr = '0; rd_en = 1'b0;
    wr_rq = 1'b0; wr_addr = '0; wr_en = 1'b0; wr_data = '0;
    #3;
    chk_reset_outputs("reset");
    tick(); tick();
    reset_n = 1'b1;

    // Requests ignored until calibration, then read ack two cycles later.
    rd_rq = 1'b1; rd_addr = 21'h00140;
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      tick();
      seen |= rd_ack | wr_ack;
    end
    chk("precalib_no_ack", seen, 0);
    chk("precalib_busy", busy, 1);
    calib_done = 1'b1;
    tick();
    chk("calib_plus1_no_ack", rd_ack, 0);
    chk("calib_plus1_idle", busy, 0);
    tick();
    chk("calib_plus2_rd_ack", rd_ack, 1);
    tick();
    chk("rd_ack_one_cycle", rd_ack, 0);

    // Reader pass-through and dropped foreign strobe.
    rd_en = 1'b1; #1;
    chk("rd_strobe_en", mem_cmd_en, 1);
    chk("rd_strobe_cmd", mem_cmd, 0);
    chk("rd_strobe_addr", mem_addr, 32'h00140);
    tick();
    rd_en = 1'b0; wr_en = 1'b1; wr_data = 32'hDEADBEEF; wr_addr = 21'h0ABCD; #1;
    chk("foreign_wr_en_dropped", mem_cmd_en, 0);
    chk("foreign_wr_data_held", mem_wr_data, 0);
    chk("foreign_addr_kept", mem_addr, 32'h00140);
    tick();
    wr_en = 1'b0; rd_rq = 1'b0;

    // Release: exactly CMD_GAP busy cycles, strobes blocked, address held.
    tick();
    rd_en = 1'b1; wr_en = 1'b1; #1;
    k = 0; seen = 1'b0;
    while (busy && k < 20) begin
      k++;
      seen |= mem_cmd_en;
      tick();
    end
    rd_en = 1'b0; wr_en = 1'b0;
    chk("gap_busy_cycles", k, 4);
    chk("gap_no_strobe", seen, 0);
    chk("gap_addr_held", mem_addr, 32'h00140);
    chk("gap_cmd_held", mem_cmd, 0);

    // Simultaneous requests alternate write, read, write, read.
    wr_rq = 1'b1; rd_rq = 1'b1; wr_addr = 21'h00200; rd_addr = 21'h00300;
    prev = 0;
    for (int g = 0; g < 4; g++) begin
      wait_ack();
      chk("tie_order", {rd_ack, wr_ack}, (g % 2 == 1) ? 2'b10 : 2'b01);
      if (g > 0) chk("ack_spacing_ge6", (cycle - prev) >= 6, 1);
      prev = cycle;
      tick();
      if (g % 2 == 1) rd_rq = 1'b0; else wr_rq = 1'b0;
      tick();
      if (g < 3) begin
        if (g % 2 == 1) rd_rq = 1'b1; else wr_rq = 1'b1;
      end
    end
    wr_rq = 1'b0; rd_rq = 1'b0;
    k = 0;
    while (busy && k < 20) begin tick(); k++; end
    chk("tie_back_idle", busy, 0);

    // Watchdog: writer holds forever, reader waits its turn.
    wr_rq = 1'b1; rd_rq = 1'b1; wr_addr = 21'h1F000;
    wait_ack();
    chk("to_first_write", {rd_ack, wr_ack}, 2'b01);
    tick();
    wr_en = 1'b1; wr_data = 32'hCAFEF00D; #1;
    chk("to_wr_strobe", mem_cmd_en, 1);
    chk("to_wr_data", mem_wr_data, 32'hCAFEF00D);
    chk("to_wr_cmd", mem_cmd, 1);
    chk("to_wr_addr", mem_addr, 32'h1F000);
    tick();
    wr_en = 1'b0;
    repeat (14) tick();
    wr_en = 1'b1; #1;
    chk("to_cycle16_active", mem_cmd_en, 1);
    chk("to_cycle16_no_err", timeout_err, 0);
    tick();
    wr_data = 32'h11111111; #1;
    chk("to_forced_gap_no_strobe", mem_cmd_en, 0);
    chk("to_err_set", timeout_err, 1);
    chk("to_wdata_held", mem_wr_data, 32'hCAFEF00D);
    wr_en = 1'b0;
    wait_ack();
    chk("to_next_is_read", {rd_ack, wr_ack}, 2'b10);
    tick();
    chk("rd_active_wdata_held", mem_wr_data, 32'hCAFEF00D);
    rd_rq = 1'b0;
    tick();
    wait_ack();
    chk("to_write_regranted", {rd_ack, wr_ack}, 2'b01);
    chk("to_err_sticky", timeout_err, 1);

    // Asynchronous reset in the middle of a write grant.
    tick();
    wr_en = 1'b1; wr_addr = 21'h00155; #1;
    chk("pre_reset_strobe", mem_cmd_en, 1);
    #2;
    reset_n = 1'b0; #1;
    chk_reset_outputs("async_reset");
    calib_done = 1'b0;
    tick();
    reset_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      seen |= rd_ack | wr_ack | mem_cmd_en;
    end
    chk("post_reset_quiet", seen, 0);
    wr_en = 1'b0;
    calib_done = 1'b1;
    tick();
    chk("post_reset_no_early_ack", wr_ack, 0);
    tick();
    chk("post_reset_regrant", wr_ack, 1);

    // Calibration lost mid-grant: grant finishes, then back to waiting.
    tick();
    calib_done = 1'b0;
    tick();
    wr_rq = 1'b0; rd_rq = 1'b1;
    seen = 1'b0; k = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      seen |= rd_ack | wr_ack;
      if (busy) k++;
    end
    chk("calib_lost_no_ack", seen, 0);
    chk("calib_lost_busy", k, 20);
    calib_done = 1'b1;
    wait_ack();
    chk("calib_back_read", {rd_ack, wr_ack}, 2'b10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: observed no finish expected finish");
    $fatal(1, "bench timeout");
  end

endmodule
